fifo_rr_drain: RTL and testbench

Round-robin drain scheduler that shares one output stream between NUM_CH instances of the team's synchronous FIFO. Per channel, it watches `empty`, issues single-cycle read strobes and captures the registered read data one cycle later. It presents each word with its source channel on a valid/ready output port. Consecutive pops from one channel are capped at BURST, then the grant rotates, so every enabled non-empty channel is served.

---
 rtl/fifo_rr_drain.sv | 112 +++++++++++
 tb/tb_fifo_rr_drain.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_CH synchronous FIFOs onto one valid/ready stream.
// Sticky grant up to BURST pops, then rotation starting after the last grant.
module fifo_rr_drain #(
  parameter int NUM_CH = 4,
  parameter int DWIDTH = 8,
  parameter int BURST  = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     srst_n_i,
  input  logic [NUM_CH-1:0]        en_i,
  input  logic [NUM_CH-1:0]        empty_i,
  output logic [NUM_CH-1:0]        rd_o,
  input  logic [NUM_CH*DWIDTH-1:0] rddata_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DWIDTH-1:0]        out_data_o,
  output logic [CH_W-1:0]          out_ch_o,
  output logic                     busy_o
);

  localparam int BW = $clog2(BURST + 1);

  typedef enum logic {SEL, LAND} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              vld_q, vld_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] rd_c;
  logic              sticky;
  logic              found;
  logic [CH_W-1:0]   win;
  logic [CH_W-1:0]   idx;
  logic              slot_free;

  // grant itself is visited last in the rotation scan
  always_comb begin
    elig   = en_i & ~empty_i;
    sticky = (burst_q < BW'(BURST)) && elig[grant_q];
    found  = sticky;
    win    = grant_q;
    idx    = '0;
    if (!sticky) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        idx = CH_W'((int'(grant_q) + i) % NUM_CH);
        if (!found && elig[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign slot_free = ~vld_q | out_ready_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    burst_d = burst_q;
    vld_d   = vld_q & ~out_ready_i;
    data_d  = data_q;
    ch_d    = ch_q;
    rd_c    = '0;
    unique case (state_q)
      SEL: begin
        if (found && slot_free) begin
          rd_c[win] = 1'b1;
          grant_d   = win;
          burst_d   = sticky ? burst_q + BW'(1) : BW'(1);
          state_d   = LAND;
        end
      end
      LAND: begin
        vld_d   = 1'b1;
        data_d  = rddata_i[int'(grant_q)*DWIDTH +: DWIDTH];
        ch_d    = grant_q;
        state_d = SEL;
      end
      default: state_d = SEL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= SEL;
      grant_q <= CH_W'(NUM_CH - 1);
      burst_q <= BW'(BURST);
      vld_q   <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign rd_o        = rd_c & {NUM_CH{srst_n_i}};
  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;
  assign out_ch_o    = ch_q;
  assign busy_o      = (state_q == LAND);

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain with a behavioural FIFO per channel.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_fifo_rr_drain;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic            clk = 1'b0;
  logic            srst_n = 1'b0;
  logic [NCH-1:0]  en = '1;
  logic [NCH-1:0]  empty = '1;
  logic [NCH-1:0]  rd;
  logic [NCH*DW-1:0] rddata = '0;
  logic            ovld;
  logic            ordy = 1'b1;
  logic [DW-1:0]   odat;
  logic [1:0]      och;
  logic            busy;

  fifo_rr_drain #(.NUM_CH(NCH), .DWIDTH(DW), .BURST(4)) dut (
    .clk_i(clk), .srst_n_i(srst_n), .en_i(en), .empty_i(empty),
    .rd_o(rd), .rddata_i(rddata), .out_valid_o(ovld),
    .out_ready_i(ordy), .out_data_o(odat), .out_ch_o(och),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq [NCH][$];
  logic [DW-1:0] rdq [NCH];

  int st_ch[$], st_cy[$];
  int o_dat[$], o_ch[$], o_cy[$];

  logic [NCH-1:0] rd_l;
  logic           vld_l, busy_l;
  logic [DW-1:0]  dat_l;
  logic [1:0]     ch_l;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < NCH; k++) begin
      empty[k] = (fq[k].size() == 0);
      rddata[k*DW +: DW] = rdq[k];
    end
  endtask

  task automatic load(input int c, input logic [DW-1:0] v);
    fq[c].push_back(v);
    refresh();
  endtask

  task automatic clear_logs();
    st_ch.delete(); st_cy.delete();
    o_dat.delete(); o_ch.delete(); o_cy.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    rd_l = rd; vld_l = ovld; busy_l = busy;
    dat_l = odat; ch_l = och;
    for (int k = 0; k < NCH; k++)
      if (rd_l[k]) begin
        st_ch.push_back(k);
        st_cy.push_back(cyc);
      end
    if (vld_l && ordy) begin
      o_dat.push_back(int'(dat_l));
      o_ch.push_back(int'(ch_l));
      o_cy.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++)
      if (rd_l[k] && fq[k].size() > 0) rdq[k] = fq[k].pop_front();
    refresh();
    cyc++;
  endtask

  task automatic reset_all();
    srst_n = 1'b0;
    for (int k = 0; k < NCH; k++) fq[k].delete();
    refresh();
    tick();
    tick();
    clear_logs();
  endtask

  int exp_ch[$];
  int cnt[NCH];
  int guard;

  initial begin
    #1;
    // reset with non-empty channels
    srst_n = 1'b0; en = '1; ordy = 1'b1;
    for (int k = 0; k < NCH; k++) load(k, 8'(8'h10 * k + 1));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_rd", int'(rd_l), 0);
      check("rst_vld", int'(vld_l), 0);
      check("rst_dat", int'(dat_l), 0);
      check("rst_busy", int'(busy_l), 0);
    end
    srst_n = 1'b1;
    tick();
    check("rst_first_rd", int'(rd_l), 4'b0001);

    // single channel ch2
    reset_all();
    load(2, 8'hA1); load(2, 8'hA2); load(2, 8'hA3);
    srst_n = 1'b1;
    repeat (12) tick();
    check("ch2_nstb", st_ch.size(), 3);
    for (int i = 0; i < st_ch.size() && i < 3; i++) begin
      check("ch2_stb_ch", st_ch[i], 2);
      check("ch2_stb_cy", st_cy[i] - st_cy[0], 2 * i);
    end
    check("ch2_nout", o_dat.size(), 3);
    for (int i = 0; i < o_dat.size() && i < 3; i++) begin
      check("ch2_dat", o_dat[i], 8'hA1 + i);
      check("ch2_ch", o_ch[i], 2);
      check("ch2_lat", o_cy[i] - st_cy[0], 2 * i + 2);
    end

    // burst rotation, 10 words per channel
    reset_all();
    for (int c = 0; c < NCH; c++)
      for (int j = 0; j < 10; j++) load(c, 8'(c * 16 + j));
    exp_ch.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++)
        repeat (4) exp_ch.push_back(c);
    for (int c = 0; c < NCH; c++) repeat (2) exp_ch.push_back(c);
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    srst_n = 1'b1;
    repeat (90) tick();
    check("rot_nout", o_dat.size(), 40);
    for (int i = 0; i < o_dat.size() && i < 40; i++) begin
      check("rot_ch", o_ch[i], exp_ch[i]);
      check("rot_dat", o_dat[i], exp_ch[i] * 16 + cnt[exp_ch[i]]);
      cnt[exp_ch[i]]++;
    end
    for (int i = 1; i < st_cy.size(); i++)
      check("rot_cadence", st_cy[i] - st_cy[i-1], 2);

    // lone ch1 across the burst limit
    reset_all();
    for (int j = 0; j < 6; j++) load(1, 8'(8'h30 + j));
    srst_n = 1'b1;
    repeat (16) tick();
    check("lone_nstb", st_ch.size(), 6);
    for (int i = 0; i < st_ch.size() && i < 6; i++) begin
      check("lone_ch", st_ch[i], 1);
      check("lone_cy", st_cy[i] - st_cy[0], 2 * i);
    end
    check("lone_nout", o_dat.size(), 6);
    for (int i = 0; i < o_dat.size() && i < 6; i++)
      check("lone_dat", o_dat[i], 8'h30 + i);

    // backpressure
    reset_all();
    load(0, 8'h55); load(3, 8'h77);
    ordy = 1'b0;
    srst_n = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!vld_l && guard < 10);
    check("bp_reach_valid", int'(vld_l), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_vld", int'(vld_l), 1);
      check("bp_dat", int'(dat_l), 8'h55);
      check("bp_ch", int'(ch_l), 0);
      check("bp_rd", int'(rd_l), 0);
    end
    ordy = 1'b1;
    tick();
    check("bp_release_rd", int'(rd_l), 4'b1000);
    check("bp_release_hs", o_dat.size(), 1);
    tick();
    tick();
    check("bp_next_vld", int'(vld_l), 1);
    check("bp_next_dat", int'(dat_l), 8'h77);
    check("bp_next_ch", int'(ch_l), 3);

    // enable mask then reset during LAND
    reset_all();
    for (int c = 0; c < NCH; c++)
      for (int j = 0; j < 6; j++) load(c, 8'(c * 16 + j));
    en = 4'b1010;
    srst_n = 1'b1;
    repeat (16) tick();
    exp_ch.delete();
    repeat (4) exp_ch.push_back(1);
    repeat (4) exp_ch.push_back(3);
    check("mask_nstb", st_ch.size(), 8);
    for (int i = 0; i < st_ch.size() && i < 8; i++)
      check("mask_ch", st_ch[i], exp_ch[i]);
    guard = 0;
    do begin
      tick();
      guard++;
    end while (rd_l == '0 && guard < 5);
    check("mask_reach_stb", int'(rd_l != '0), 1);
    srst_n = 1'b0;
    tick();
    check("mrst_busy", int'(busy_l), 1);
    tick();
    check("mrst_vld", int'(vld_l), 0);
    check("mrst_busy2", int'(busy_l), 0);
    srst_n = 1'b1;
    tick();
    check("mrst_first_rd", int'(rd_l), 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
